mux8way16_rr_arbiter: RTL and testbench
=======================================

// Module: mux8way16_rr_arbiter
// PURPOSE
//  Shares one Mux8Way16 datapath between 8 requesters, each offering one 16-bit word per request.
//  Round-robin arbiter: registers the 3-bit select, drives the Mux8Way16 instance, and presents the
//  chosen word to one downstream consumer over a valid/ready handshake. Acks the winning source.
//  Sits between per-source producers and a single shared 16-bit sink (bus, register, port).
// PARAMETERS
//  (none) -- width 16 and 8 ways are fixed by the Mux8Way16 datapath.
// PORTS
//  clk        in   1    single clock, rising edge
//  reset      in   1    synchronous, active-high
//  req        in   8    req[i]=1: source i offers in_data[16*i+15:16*i]
//  in_data    in   128  8 x 16-bit source words, packed; source i at bits 16*i+15:16*i
//  out_valid  out  1    out_data/out_src hold a granted word
//  out_ready  in   1    sink accepts word when out_valid && out_ready
//  out_data   out  16   granted word (Mux8Way16 output, select = registered sel)
//  out_src    out  3    index of granted source (= sel)
//  ack        out  8    one-hot 1-cycle pulse to source whose word was accepted
//  lock       in   8    only when RR_ARB_LOCK_EN defined; see CONFIGURATION
// BEHAVIOUR
//  - Reset (sync, on clk edge with reset=1): out_valid=0, ack=0, sel/out_src=0, ptr=7, state=IDLE.
//    Reset wins over every other event in the same cycle, including a pending handshake (no ack).
//  - out_data = Mux8Way16(in_data words, sel). It is combinational from registered sel + in_data.
//  - Source rule: once req[i]=1, the source holds req[i] and its word stable until ack[i].
//    The block does not check this. A dropped req with out_valid=1 does not revoke the grant.
//  - Round-robin pick: search order ptr+1, ptr+2, ..., ptr+7, ptr (mod 8). The first set bit wins.
//    ptr = last granted index. After reset, index 0 has top priority.
//  - State IDLE (out_valid=0): if |req, latch winner into sel, set ptr=winner, go GRANT.
//    out_valid=1 next cycle, so latency is req high -> out_valid after 1 clk.
//    If req==0, stay IDLE.
//  - State GRANT (out_valid=1): out_data/out_src stable while out_ready=0. Grant is never preempted.
//  - Handshake cycle (out_valid && out_ready):
//    - ack[sel] pulses next cycle for exactly 1 clk.
//    - Arbitrate among req & ~onehot(sel), so the accepted source is masked this cycle.
//    - If any bit is set: load new sel/ptr, stay GRANT with out_valid=1 (back-to-back, 1 word/clk).
//    - Otherwise: out_valid=0, go IDLE.
//  - Sole requester re-requesting: its next word is granted 1 clk after ack, via IDLE.
//  - Sink-side fairness: with all 8 requesting continuously, grant order is 0,1,...,7,0...
//    A source waits at most 7 grants.
//  - ack is never asserted for more than one source, nor in a cycle with reset=1.
// CONFIGURATION
//  - Macro RR_ARB_LOCK_EN:
//    - Defined: port lock[7:0] exists. On a handshake where lock[sel]=1 and req[sel]=1, the grant
//      stays with sel: masking is skipped, ptr is unchanged, out_valid stays 1, ack[sel] still pulses.
//      This gives burst transfers. Lock is ignored in IDLE picks.
//    - Undefined: no lock port. Pure round-robin as above.
// TESTING
//  1. Reset, then req=8'h00 for 5 clk -> out_valid=0, ack=0, out_src=0 throughout.
//  2. req=8'h01, word0=16'hA5A5, out_ready=1 -> out_valid clk+1 with out_data=A5A5, out_src=0;
//     ack=8'h01 the following clk; out_valid drops if req is then cleared.
//  3. req=8'hFF, all words = 16'h1000+i, out_ready=1 held -> out_src 0..7,0 on consecutive clks,
//     out_data=1000..1007, one ack bit per cycle matching.
//  4. req=8'h84 with out_ready=0 for 4 clk -> out_src=2, out_data stable for 4 clk, no ack;
//     then out_ready=1 -> ack=8'h04, next out_src=7.
//  5. Mid-grant (out_valid=1, out_ready=1) assert reset 1 clk -> no ack; next clk out_valid=0,
//     ptr=7; with req=8'h81, next grant is source 0.
//  6. RR_ARB_LOCK_EN: req=8'h03, lock=8'h01 for 3 handshakes -> out_src=0 three times,
//     then lock=0 -> out_src=1.

Source files
------------

// File: rtl/mux8way16_rr_arbiter.sv
// Round-robin arbiter that shares one Mux8Way16 datapath among 8 sources behind a valid/ready sink.
// Optional macro RR_ARB_LOCK_EN adds lock[7:0] so a locked grant can stay with its source (burst).
`timescale 1ns/1ps

module mux8way16 (
    input  logic [127:0] in_data_i,
    input  logic [2:0]   sel_i,
    output logic [15:0]  out_o
);
    // NOTE: assigning a default before the case means no path leaves out_o unassigned, so no latch.
    always_comb begin
        out_o = 16'h0000;
        case (sel_i)
            3'd0: out_o = in_data_i[15:0];
            3'd1: out_o = in_data_i[31:16];
            3'd2: out_o = in_data_i[47:32];
            3'd3: out_o = in_data_i[63:48];
            3'd4: out_o = in_data_i[79:64];
            3'd5: out_o = in_data_i[95:80];
            3'd6: out_o = in_data_i[111:96];
            3'd7: out_o = in_data_i[127:112];
            default: out_o = 16'h0000;
        endcase
    end
endmodule

module mux8way16_rr_arbiter (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   req,
    input  logic [127:0] in_data,
`ifdef RR_ARB_LOCK_EN
    input  logic [7:0]   lock,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [15:0]  out_data,
    output logic [2:0]   out_src,
    output logic [7:0]   ack
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Search ptr+1 .. ptr+7, then ptr; walking from farthest to nearest lets the nearest hit win.
    function automatic pick_t rr_pick(input logic [7:0] cand, input logic [2:0] ptr);
        pick_t      res;
        logic [2:0] idx;
        res = '0;
        for (int k = 8; k >= 1; k--) begin
            idx = ptr + 3'(k);
            if (cand[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

    state_e     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] ack_q, ack_d;

    logic [7:0] sel_onehot;
    logic       keep_grant;
    pick_t      pick_idle;
    pick_t      pick_next;

    assign sel_onehot = 8'(1) << sel_q;
    assign pick_idle  = rr_pick(req, ptr_q);
    assign pick_next  = rr_pick(req & ~sel_onehot, ptr_q);

`ifdef RR_ARB_LOCK_EN
    assign keep_grant = lock[sel_q] & req[sel_q];
`else
    assign keep_grant = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        ack_d   = 8'h00;
        case (state_q)
            IDLE: begin
                if (pick_idle.found) begin
                    sel_d   = pick_idle.idx;
                    ptr_d   = pick_idle.idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (out_ready) begin
                    ack_d = sel_onehot;
                    if (keep_grant) begin
                        state_d = GRANT;
                    end else if (pick_next.found) begin
                        sel_d = pick_next.idx;
                        ptr_d = pick_next.idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            ptr_q   <= 3'd7;
            ack_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
        end
    end

    assign out_valid = (state_q == GRANT);
    assign out_src   = sel_q;
    // A pending ack is suppressed in any cycle where reset is high.
    assign ack       = reset ? 8'h00 : ack_q;

    mux8way16 u_mux (
        .in_data_i (in_data),
        .sel_i     (sel_q),
        .out_o     (out_data)
    );
endmodule

// File: tb/tb_mux8way16_rr_arbiter.sv
// Scoreboard bench for mux8way16_rr_arbiter: stimulus pushes expected transfers/acks, a monitor pops them.
// Exercises the lock burst case when RR_ARB_LOCK_EN is defined.
`timescale 1ns/1ps

module tb_mux8way16_rr_arbiter;
    logic         clk;
    logic         reset;
    logic [7:0]   req;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_data;
    logic [2:0]   out_src;
    logic [7:0]   ack;
`ifdef RR_ARB_LOCK_EN
    logic [7:0]   lock;
`endif

    typedef struct packed {
        logic [2:0]  src;
        logic [15:0] data;
    } xfer_t;

    xfer_t      exp_xfer_q[$];
    logic [7:0] exp_ack_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    mux8way16_rr_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .in_data   (in_data),
`ifdef RR_ARB_LOCK_EN
        .lock      (lock),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .ack       (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] src, input logic [15:0] data);
        xfer_t x;
        x.src  = src;
        x.data = data;
        exp_xfer_q.push_back(x);
        exp_ack_q.push_back(8'(1) << src);
    endtask

    task automatic set_words(input logic [15:0] base);
        for (int i = 0; i < 8; i++) in_data[16*i +: 16] = base + 16'(i);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        req       = 8'h00;
        out_ready = 1'b0;
`ifdef RR_ARB_LOCK_EN
        lock      = 8'h00;
`endif
        cyc();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && (exp_xfer_q.size() != 0 || exp_ack_q.size() != 0); i++)
            @(negedge clk);
        #1;
        check({name, "_pending_xfers"}, 32'(exp_xfer_q.size()), 32'h0);
        check({name, "_pending_acks"}, 32'(exp_ack_q.size()), 32'h0);
        exp_xfer_q.delete();
        exp_ack_q.delete();
    endtask

    // Monitor: every accepted word and every ack pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (ack != 8'h00) check("ack_during_reset", 32'(ack), 32'h0);
        end else begin
            if (out_valid && out_ready) begin
                if (exp_xfer_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL xfer_unexpected: got src %0d data %0h expected none", out_src, out_data);
                end else begin
                    xfer_t e;
                    e = exp_xfer_q.pop_front();
                    check("xfer_src", 32'(out_src), 32'(e.src));
                    check("xfer_data", 32'(out_data), 32'(e.data));
                end
            end
            if (ack != 8'h00) begin
                if (exp_ack_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL ack_unexpected: got %0h expected 0", ack);
                end else begin
                    logic [7:0] ea;
                    ea = exp_ack_q.pop_front();
                    check("ack_value", 32'(ack), 32'(ea));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        req       = 8'h00;
        out_ready = 1'b0;
        in_data   = '0;
`ifdef RR_ARB_LOCK_EN
        lock      = 8'h00;
`endif
        repeat (2) @(posedge clk);

        // Test 1: idle with no requests.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t1_valid", 32'(out_valid), 32'h0);
            check("t1_ack", 32'(ack), 32'h0);
            check("t1_src", 32'(out_src), 32'h0);
            cyc();
        end

        // Test 2: single requester, one word.
        do_reset();
        in_data[15:0] = 16'hA5A5;
        req           = 8'h01;
        out_ready     = 1'b1;
        push(3'd0, 16'hA5A5);
        @(negedge clk);
        check("t2_valid_before_edge", 32'(out_valid), 32'h0);
        cyc();
        req = 8'h00;
        cyc();
        @(negedge clk);
        check("t2_valid_drop", 32'(out_valid), 32'h0);
        drain("t2");

        // Test 3: all eight requesting, back-to-back round-robin.
        do_reset();
        set_words(16'h1000);
        req       = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(3'(i), 16'h1000 + 16'(i));
        push(3'd0, 16'h1000);
        cyc();
        for (int i = 0; i < 8; i++) cyc();
        req = 8'h00;
        cyc();
        out_ready = 1'b0;
        drain("t3");

        // Test 4: stalled sink holds the grant, then release.
        do_reset();
        set_words(16'h1000);
        req = 8'h84;
        cyc();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_stall_valid", 32'(out_valid), 32'h1);
            check("t4_stall_src", 32'(out_src), 32'h2);
            check("t4_stall_data", 32'(out_data), 32'h1002);
            check("t4_stall_ack", 32'(ack), 32'h0);
            cyc();
        end
        push(3'd2, 16'h1002);
        push(3'd7, 16'h1007);
        out_ready = 1'b1;
        cyc();
        req = 8'h80;
        cyc();
        req       = 8'h00;
        out_ready = 1'b0;
        drain("t4");

        // Test 5: reset during a pending handshake.
        do_reset();
        set_words(16'h3000);
        req = 8'h81;
        cyc();
        @(negedge clk);
        check("t5_pre_valid", 32'(out_valid), 32'h1);
        check("t5_pre_src", 32'(out_src), 32'h0);
        cyc();
        reset     = 1'b1;
        out_ready = 1'b1;
        cyc();
        reset = 1'b0;
        push(3'd0, 16'h3000);
        push(3'd7, 16'h3007);
        @(negedge clk);
        check("t5_post_valid", 32'(out_valid), 32'h0);
        check("t5_post_src", 32'(out_src), 32'h0);
        check("t5_post_ack", 32'(ack), 32'h0);
        cyc();
        cyc();
        req = 8'h80;
        cyc();
        req       = 8'h00;
        out_ready = 1'b0;
        drain("t5");

`ifdef RR_ARB_LOCK_EN
        // Test 6: locked burst from source 0, then release to source 1.
        do_reset();
        set_words(16'h4000);
        req       = 8'h03;
        lock      = 8'h01;
        out_ready = 1'b1;
        push(3'd0, 16'h4000);
        push(3'd0, 16'h4000);
        push(3'd0, 16'h4000);
        push(3'd1, 16'h4001);
        cyc();
        cyc();
        cyc();
        lock = 8'h00;
        cyc();
        req = 8'h02;
        cyc();
        req       = 8'h00;
        out_ready = 1'b0;
        drain("t6");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
